// File: rtl/sda_tx_arb.sv
// ---------------------------------------------------------------------------
// sda_tx_arb
//   Round-robin arbiter that loads one 4-bit word at a time from one of four
//   requesters and presents it to a serial transmitter. The transmitter asks
//   for new data with tx_ack. The first rising edge of tx_ack after a word is
//   loaded hands that word over: gnt pulses for the owning requester.
//   If no rising edge arrives within TIMEOUT cycles, the loaded word is
//   abandoned and a sticky timeout_err flag is raised.
//
// Parameters
//   TIMEOUT     : maximum number of LOADED cycles a word waits for a rising
//                 edge of tx_ack before it is abandoned (1..255)
//
// Ports
//   sclk        : clock, all state updates on the rising edge
//   rst         : synchronous reset, active low
//   req         : per-requester request, bit i = requester i has a word
//   req_data    : requester words, requester i word = req_data[4i+3:4i]
//   gnt         : one-hot, one-cycle pulse when a word is handed over
//   tx_data     : word presented to the serial transmitter
//   tx_ack      : transmitter new-data request (asynchronous to the word)
//   tx_hold     : high while no word is loaded
//   src         : index of the requester whose word is on tx_data
//   busy        : high in LOADED and SENDING
//   frame_cnt   : number of words handed over, wraps 255 -> 0
//   timeout_err : sticky flag, a loaded word was abandoned
//   err_clr     : synchronous clear of timeout_err
// ---------------------------------------------------------------------------
module sda_tx_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_data,
  output logic [3:0]  gnt,
  output logic [3:0]  tx_data,
  input  logic        tx_ack,
  output logic        tx_hold,
  output logic [1:0]  src,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    SENDING = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] wait_cnt;
  logic       ack_q;
  logic       ack_p;

  logic       rise;
  logic       low;
  logic [7:0] wait_nxt;
  logic       found;
  logic [1:0] win_idx;
  logic [3:0] win_word;

  assign rise     = ack_q & ~ack_p;
  assign low      = ~ack_q;
  assign wait_nxt = wait_cnt + 8'd1;

  // Round-robin search starting at ptr. The 2-bit sum wraps modulo 4, so
  // the search covers ptr, ptr+1, ptr+2 and ptr+3 in priority order.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        found   = 1'b1;
        win_idx = ptr + 2'(i);
      end
    end
    win_word = req_data[4*win_idx +: 4];
  end

  // tx_ack is registered once into ack_q, and ack_q is delayed once more
  // into ack_p. Edge detection uses only the registered copies.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      ack_q <= 1'b0;
      ack_p <= 1'b0;
    end else begin
      ack_q <= tx_ack;
      ack_p <= ack_q;
    end
  end

  // Main FSM. All outputs are registered here.
  // err_clr is applied first so that a timeout set later in the same cycle
  // overrides it.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      wait_cnt    <= 8'd0;
      tx_hold     <= 1'b1;
      tx_data     <= 4'd0;
      src         <= 2'd0;
      gnt         <= 4'd0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      gnt <= 4'd0;
      if (err_clr)
        timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= win_word;
            src      <= win_idx;
            tx_hold  <= 1'b0;
            wait_cnt <= 8'd0;
            busy     <= 1'b1;
            state    <= LOADED;
          end else begin
            tx_hold <= 1'b1;
          end
        end

        // A rising edge of tx_ack wins over a timeout expiring in the same cycle.
        LOADED: begin
          if (rise) begin
            gnt       <= 4'b0001 << src;
            frame_cnt <= frame_cnt + 8'd1;
            ptr       <= src + 2'd1;
            state     <= SENDING;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == TIMEOUT_W) begin
              timeout_err <= 1'b1;
              tx_hold     <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end

        // The word stays on tx_data until the transmitter drops tx_ack.
        // tx_hold rises here because the handed-over word is no longer pending.
        SENDING: begin
          if (low) begin
            tx_hold <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          tx_hold <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sda_tx_arb.md
SDA_TX_ARB -- requirements
Module: sda_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of sclk cycles a loaded word waits for a transmitter request before being abandoned (range 1..255).
REQ-002 sclk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i high = requester i has a word pending.
REQ-005 req_data  input  16  requester words; requester i word = req_data[4i+3:4i].
REQ-006 gnt  output  4  one-hot, one-cycle pulse; word of requester i handed to transmitter.
REQ-007 tx_data  output  4  parallel word presented to the serial transmitter.
REQ-008 tx_ack  input  1  transmitter new-data request; the transmitter latches tx_data on its rising edge.
REQ-009 tx_hold  output  1  high = no word loaded; transmitter must stay in ready/idle.
REQ-010 src  output  2  index of the requester whose word is on tx_data.
REQ-011 busy  output  1  high in LOADED and SENDING.
REQ-012 frame_cnt  output  8  count of words handed over, wraps 255->0.
REQ-013 timeout_err  output  1  sticky flag; a loaded word was abandoned.
REQ-014 err_clr  input  1  synchronous clear of timeout_err.

Function
REQ-015 tx_ack shall be registered once (ack_q) and the previous sample kept (ack_p); rise = ack_q & ~ack_p, low = ~ack_q.
REQ-016 States: IDLE, LOADED, SENDING; 2-bit round-robin pointer ptr marks the highest-priority requester.
REQ-017 IDLE, req != 0: select the first set req bit searching ptr, ptr+1, ... mod 4; next cycle tx_data = winner word, src = winner, tx_hold = 0, wait counter = 0, state LOADED.
REQ-018 IDLE, req == 0: remain in IDLE; tx_hold = 1; tx_data and src keep their last values.
REQ-019 LOADED: tx_data and src are frozen; deasserting req[src] does not cancel the word.
REQ-020 LOADED, rise: gnt[src] pulses for exactly 1 cycle, frame_cnt increments, ptr = src+1 mod 4, state SENDING.
REQ-021 LOADED, no rise: wait counter increments; when it reaches TIMEOUT, timeout_err = 1, tx_hold = 1, state IDLE, no gnt, ptr unchanged.
REQ-022 If rise and the timeout expiry fall in the same cycle, rise wins (grant; no error).
REQ-023 SENDING: tx_data held; when low is seen, state IDLE, and arbitration may occur in the following cycle.
REQ-024 Latency: req asserted in IDLE -> tx_data valid 1 cycle later; tx_ack rising at the pin -> gnt 2 cycles later.
REQ-025 A requester shall hold req and req_data stable until it sees its gnt; gnt is the only consumption indication.
REQ-026 err_clr clears timeout_err next cycle; a simultaneous set takes priority over clear.
REQ-027 busy = (state != IDLE); gnt is never asserted outside the LOADED->SENDING transition.

Reset
REQ-028 When rst is low at a sclk edge: state IDLE, ptr = 0, tx_hold = 1, tx_data = 0, src = 0, gnt = 0, busy = 0, frame_cnt = 0, timeout_err = 0, wait counter = 0, ack_q = ack_p = 0.
REQ-029 Reset mid-frame (LOADED or SENDING) abandons the word without gnt; the requester re-arbitrates after reset.

Verification
REQ-030 Single request: req = 4'b0100, word 0xA; pulse tx_ack -> tx_data = 0xA, src = 2, one gnt = 4'b0100, frame_cnt = 1.
REQ-031 Round-robin: req = 4'b1111 held, words 1,2,3,4; four tx_ack pulses -> gnt order 0,1,2,3 then 0; each tx_data matches.
REQ-032 Timeout: TIMEOUT = 8, req = 4'b0001, tx_ack low -> timeout_err = 1 after 8 LOADED cycles, no gnt, tx_hold = 1; err_clr -> timeout_err = 0.
REQ-033 Withdrawal: req[1] drops while LOADED -> word still granted on the next tx_ack rise, gnt = 4'b0010.
REQ-034 Tie: tx_ack rise in the same cycle as timeout expiry -> gnt asserted, timeout_err stays 0.
REQ-035 Reset in SENDING with req = 4'b0011 -> all outputs at reset values; after release requester 0 is granted first.
